// File: rtl/apb_protocol_monitor_if.sv
// APB3 bus bundle observed by apb_protocol_monitor.
// The monitor modport is fully passive; master/slave are for whatever drives the bus.
interface apb_protocol_monitor_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

  modport monitor (
    input psel, penable, pwrite, paddr, pwdata, prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_protocol_monitor.sv
// Passive APB3 protocol monitor: sticky violation flags, per-sample pulses and
// saturating completion/error statistics. Drives nothing on the bus.
module apb_protocol_monitor #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_n,
  apb_protocol_monitor_if.monitor bus,
  input  logic                  clr_i,
  output logic [5:0]            err_o,
  output logic [5:0]            err_pulse_o,
  output logic                  xfer_done_o,
  output logic [CNT_W-1:0]      wr_cnt_o,
  output logic [CNT_W-1:0]      rd_cnt_o,
  output logic [CNT_W-1:0]      err_cnt_o
);

  localparam int unsigned WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cap_addr_q;
  logic [DATA_W-1:0] cap_wdata_q;
  logic              cap_write_q;
  logic [WC_W-1:0]   wait_cnt_q, wc_d;
  logic [5:0]        pulse_d;
  logic              done_d;
  logic              capture;
  logic              access_s;
  logic              mismatch;

  assign access_s = (state_q != IDLE) && bus.psel && bus.penable;
  assign mismatch = (bus.paddr != cap_addr_q) || (bus.pwrite != cap_write_q) ||
                    (cap_write_q && (bus.pwdata != cap_wdata_q));

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // The first enable sample after SETUP is itself an access sample and may complete.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.psel && !bus.penable) state_d = SETUP;
      SETUP: begin
        if (!bus.psel)        state_d = IDLE;
        else if (bus.penable) state_d = bus.pready ? IDLE : ACCESS;
      end
      ACCESS: begin
        if (!bus.psel)         state_d = IDLE;
        else if (!bus.penable) state_d = SETUP;
        else if (bus.pready)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pulse_d = '0;
    done_d  = 1'b0;
    capture = 1'b0;
    wc_d    = wait_cnt_q;
    unique case (state_q)
      IDLE: begin
        capture    = bus.psel && !bus.penable;
        pulse_d[1] = bus.psel && bus.penable;
      end
      SETUP: begin
        pulse_d[0] = !bus.psel || !bus.penable;
        capture    = bus.psel && !bus.penable;
        pulse_d[2] = access_s && mismatch;
      end
      ACCESS: begin
        pulse_d[5] = !bus.psel || !bus.penable;
        capture    = bus.psel && !bus.penable;
        pulse_d[2] = bus.psel && mismatch;
      end
      default: ;
    endcase
    if (access_s) begin
      if (bus.pready) begin
        done_d = 1'b1;
      end else begin
        wc_d       = (wait_cnt_q == WC_MAX) ? WC_MAX : wait_cnt_q + WC_W'(1);
        pulse_d[3] = (wc_d == WC_MAX) && (wait_cnt_q != WC_MAX);
      end
    end
    if (capture) wc_d = '0;
    pulse_d[4] = bus.pslverr && !(access_s && bus.pready);
  end

  function automatic logic [CNT_W-1:0] cnt_next(logic [CNT_W-1:0] cur, logic inc, logic clr);
    if (clr) return CNT_W'(inc);
    return (inc && (cur != '1)) ? cur + CNT_W'(1) : cur;
  endfunction

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      cap_write_q <= 1'b0;
      wait_cnt_q  <= '0;
      err_o       <= '0;
      err_pulse_o <= '0;
      xfer_done_o <= 1'b0;
      wr_cnt_o    <= '0;
      rd_cnt_o    <= '0;
      err_cnt_o   <= '0;
    end else begin
      if (capture) begin
        cap_addr_q  <= bus.paddr;
        cap_wdata_q <= bus.pwdata;
        cap_write_q <= bus.pwrite;
      end
      wait_cnt_q  <= wc_d;
      err_pulse_o <= pulse_d;
      xfer_done_o <= done_d;
      err_o       <= (clr_i ? 6'b0 : err_o) | pulse_d;
      wr_cnt_o    <= cnt_next(wr_cnt_o, done_d && cap_write_q, clr_i);
      rd_cnt_o    <= cnt_next(rd_cnt_o, done_d && !cap_write_q, clr_i);
      err_cnt_o   <= cnt_next(err_cnt_o, |pulse_d, clr_i);
    end
  end

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Scoreboard bench: two monitors with different TIMEOUT/CNT_W watch one shared bus,
// checked every cycle against a transaction-level reference model.
module tb_apb_protocol_monitor;
  localparam int TO_A = 16, TO_B = 4;
  localparam int MAX_A = 255, MAX_B = 3;

  logic clk_i = 1'b0;
  logic reset_n = 1'b0;
  logic clr_i = 1'b0;
  always #5 clk_i = ~clk_i;

  apb_protocol_monitor_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  logic [5:0] a_err, a_pulse, b_err, b_pulse;
  logic       a_done, b_done;
  logic [7:0] a_wr, a_rd, a_ec;
  logic [1:0] b_wr, b_rd, b_ec;

  apb_protocol_monitor #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO_A), .CNT_W(8)) dut_a (
    .clk_i(clk_i), .reset_n(reset_n), .bus(bus), .clr_i(clr_i),
    .err_o(a_err), .err_pulse_o(a_pulse), .xfer_done_o(a_done),
    .wr_cnt_o(a_wr), .rd_cnt_o(a_rd), .err_cnt_o(a_ec)
  );

  apb_protocol_monitor #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO_B), .CNT_W(2)) dut_b (
    .clk_i(clk_i), .reset_n(reset_n), .bus(bus), .clr_i(clr_i),
    .err_o(b_err), .err_pulse_o(b_pulse), .xfer_done_o(b_done),
    .wr_cnt_o(b_wr), .rd_cnt_o(b_rd), .err_cnt_o(b_ec)
  );

  typedef struct { int err; int pulse; int done; int wr; int rd; int ec; } exp_t;
  exp_t qa[$], qb[$];
  exp_t ma, mb;
  int n_tests = 0, n_fail = 0;

  // Reference model: phase 0 = no transfer open, 1 = setup seen, 2 = inside access.
  int         phase, waits;
  logic [7:0] c_addr, c_wd;
  bit         c_wr;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(int cur, bit inc, int mx, bit clr);
    if (clr) return inc ? 1 : 0;
    return (cur + int'(inc) > mx) ? mx : cur + int'(inc);
  endfunction

  function automatic exp_t upd(exp_t m, int p, bit d, bit w, int mx, bit clr);
    exp_t r;
    r.pulse = p;
    r.done  = d ? 1 : 0;
    r.err   = (clr ? 0 : m.err) | p;
    r.wr    = sat(m.wr, d && w, mx, clr);
    r.rd    = sat(m.rd, d && !w, mx, clr);
    r.ec    = sat(m.ec, p != 0, mx, clr);
    return r;
  endfunction

  task automatic model_reset();
    phase = 0; waits = 0; c_addr = 0; c_wd = 0; c_wr = 0;
    ma = '{default: 0};
    mb = '{default: 0};
  endtask

  task automatic model_step(bit sel, bit en, bit wr, logic [7:0] a, logic [7:0] wd,
                            bit rdy, bit slv, bit clr);
    int p = 0;
    int np = phase;
    bit acc, comp, d = 0, xw = 0, e3a = 0, e3b = 0;
    acc  = (phase != 0) && sel && en;
    comp = acc && rdy;
    if (sel && (phase == 2 || (phase == 1 && en)) &&
        (a != c_addr || wr != c_wr || (c_wr && wd != c_wd))) p |= 4;
    case (phase)
      0: if (sel && en) p |= 2; else if (sel) np = 1;
      1: if (!sel) begin p |= 1; np = 0; end else if (!en) p |= 1;
      default: if (!sel) begin p |= 32; np = 0; end
               else if (!en) begin p |= 32; np = 1; end
    endcase
    if (acc) begin
      if (rdy) begin
        d = 1; xw = c_wr; np = 0;
      end else begin
        waits = (phase == 1) ? 1 : waits + 1;
        np  = 2;
        e3a = (waits == TO_A - 1);
        e3b = (waits == TO_B - 1);
      end
    end
    if (slv && !comp) p |= 16;
    if (sel && !en) begin c_addr = a; c_wr = wr; c_wd = wd; end
    ma = upd(ma, p | (e3a ? 8 : 0), d, xw, MAX_A, clr);
    mb = upd(mb, p | (e3b ? 8 : 0), d, xw, MAX_B, clr);
    phase = np;
  endtask

  // Drives one sample (called at a negedge), queues its expectation, advances a cycle.
  task automatic cyc(bit sel, bit en, bit wr, logic [7:0] a, logic [7:0] wd,
                     bit rdy, bit slv, bit clr);
    bus.psel    = sel;
    bus.penable = en;
    bus.pwrite  = wr;
    bus.paddr   = sel ? a : 8'hxx;
    bus.pwdata  = wd;
    bus.prdata  = rdy ? 8'h3C : 8'h00;
    bus.pready  = rdy;
    bus.pslverr = slv;
    clr_i       = clr;
    if (!reset_n) model_reset();
    else          model_step(sel, en, wr, a, wd, rdy, slv, clr);
    qa.push_back(ma);
    qb.push_back(mb);
    @(negedge clk_i);
  endtask

  task automatic idle(bit clr);
    cyc(0, 0, 0, 8'h00, 8'h00, 0, 0, clr);
  endtask

  task automatic rc(bit sel, bit en, bit wr, logic [7:0] a, logic [7:0] wd, bit rdy);
    cyc(sel, en, wr, a, wd, rdy, $urandom_range(0, 11) == 0, $urandom_range(0, 29) == 0);
  endtask

  task automatic chk_all_zero();
    chk("rst_a_err", a_err, 0);   chk("rst_a_pulse", a_pulse, 0); chk("rst_a_done", a_done, 0);
    chk("rst_a_wr", a_wr, 0);     chk("rst_a_rd", a_rd, 0);       chk("rst_a_ec", a_ec, 0);
    chk("rst_b_err", b_err, 0);   chk("rst_b_pulse", b_pulse, 0); chk("rst_b_done", b_done, 0);
    chk("rst_b_wr", b_wr, 0);     chk("rst_b_rd", b_rd, 0);       chk("rst_b_ec", b_ec, 0);
  endtask

  // Scoreboard monitor: every sample produces an output set one cycle later.
  initial begin
    exp_t ea, eb;
    forever begin
      @(posedge clk_i);
      #1;
      if (qa.size() == 0 || qb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL scoreboard: got empty queue expected entry at %0t", $time);
      end else begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk("a_err_o", a_err, ea.err);       chk("a_err_pulse_o", a_pulse, ea.pulse);
        chk("a_xfer_done_o", a_done, ea.done);
        chk("a_wr_cnt_o", a_wr, ea.wr);      chk("a_rd_cnt_o", a_rd, ea.rd);
        chk("a_err_cnt_o", a_ec, ea.ec);
        chk("b_err_o", b_err, eb.err);       chk("b_err_pulse_o", b_pulse, eb.pulse);
        chk("b_xfer_done_o", b_done, eb.done);
        chk("b_wr_cnt_o", b_wr, eb.wr);      chk("b_rd_cnt_o", b_rd, eb.rd);
        chk("b_err_cnt_o", b_ec, eb.ec);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) idle(0);
    chk_all_zero();
    reset_n = 1'b1;
    idle(0);

    // zero-wait write
    cyc(1, 0, 1, 8'd3, 8'hA5, 0, 0, 0);
    cyc(1, 1, 1, 8'd3, 8'hA5, 1, 0, 0);
    chk("s1_done", a_done, 1); chk("s1_wr", a_wr, 1); chk("s1_err", a_err, 0);
    idle(0);
    chk("s1_done_low", a_done, 0);

    // read with 3 wait states
    cyc(1, 0, 0, 8'd5, 8'h00, 0, 0, 0);
    repeat (3) cyc(1, 1, 0, 8'd5, 8'h00, 0, 0, 0);
    cyc(1, 1, 0, 8'd5, 8'h00, 1, 0, 0);
    chk("s2_rd", a_rd, 1); chk("s2_err_a", a_err, 0); chk("s2_err_b", b_err, 8);
    idle(1);

    // read with 6 wait states
    cyc(1, 0, 0, 8'd7, 8'h00, 0, 0, 0);
    repeat (6) cyc(1, 1, 0, 8'd7, 8'h00, 0, 0, 0);
    cyc(1, 1, 0, 8'd7, 8'h00, 1, 0, 0);
    chk("s3_err_b", b_err, 8); chk("s3_ec_b", b_ec, 1); chk("s3_rd_b", b_rd, 1);
    chk("s3_err_a", a_err, 0); chk("s3_rd_a", a_rd, 1);
    idle(1);

    // address change mid-access, then pslverr while idle
    cyc(1, 0, 1, 8'd3, 8'h11, 0, 0, 0);
    cyc(1, 1, 1, 8'd3, 8'h11, 0, 0, 0);
    cyc(1, 1, 1, 8'd4, 8'h11, 0, 0, 0);
    cyc(1, 1, 1, 8'd3, 8'h11, 1, 0, 0);
    cyc(0, 0, 0, 8'd0, 8'h00, 0, 1, 0);
    chk("s4_err", a_err, 6'b010100); chk("s4_ec", a_ec, 2); chk("s4_ec_b", b_ec, 2);
    idle(1);

    // enable without setup, setup without enable, then a clean write
    cyc(1, 1, 0, 8'd0, 8'h00, 0, 0, 0);
    idle(0);
    cyc(1, 0, 1, 8'd2, 8'h5A, 0, 0, 0);
    idle(0);
    cyc(1, 0, 1, 8'd2, 8'h5A, 0, 0, 0);
    cyc(1, 1, 1, 8'd2, 8'h5A, 1, 0, 0);
    chk("s5_err", a_err, 6'b000011); chk("s5_wr", a_wr, 1); chk("s5_ec", a_ec, 2);
    idle(1);

    // back-to-back writes saturate the 2-bit counter; clear coincident with completion
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 1, 8'(i), 8'(i * 3), 0, 0, 0);
      cyc(1, 1, 1, 8'(i), 8'(i * 3), 1, 0, 0);
    end
    chk("s6_wr_b_sat", b_wr, 3); chk("s6_wr_a", a_wr, 5);
    cyc(1, 0, 1, 8'd9, 8'h77, 0, 0, 0);
    cyc(1, 1, 1, 8'd9, 8'h77, 1, 0, 1);
    chk("s6_wr_b_clr", b_wr, 1); chk("s6_wr_a_clr", a_wr, 1); chk("s6_err_b", b_err, 0);

    // asynchronous reset in the middle of an access
    cyc(1, 0, 0, 8'd1, 8'h00, 0, 1, 0);
    cyc(1, 1, 0, 8'd1, 8'h00, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    chk_all_zero();
    model_reset();
    cyc(1, 1, 0, 8'd1, 8'h00, 0, 0, 0);
    reset_n = 1'b1;
    cyc(1, 1, 0, 8'd1, 8'h00, 0, 0, 0);
    idle(0);
    chk("s7_e1", a_err, 6'b000010);

    // randomized traffic: mostly transfers, some aborts and raw noise
    for (int t = 0; t < 400; t++) begin
      int         kind, nw;
      logic [7:0] a, wd;
      bit         w;
      kind = $urandom_range(0, 9);
      a    = 8'($urandom_range(0, 3));
      wd   = 8'($urandom);
      w    = 1'($urandom_range(0, 1));
      nw   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 4);
      if (kind < 6) begin
        rc(1, 0, w, a, wd, 0);
        for (int k = 0; k < nw; k++)
          rc(1, 1, w, ($urandom_range(0, 9) == 0) ? a ^ 8'h01 : a,
             ($urandom_range(0, 9) == 0) ? wd ^ 8'h80 : wd, 0);
        rc(1, 1, w, a, wd, 1);
      end else if (kind == 6) begin
        for (int k = 0; k < $urandom_range(1, 3); k++) rc(0, 0, 0, 8'h00, 8'h00, 0);
      end else if (kind == 7) begin
        rc(1, 0, w, a, wd, 0);
        for (int k = 0; k < nw; k++) rc(1, 1, w, a, wd, 0);
        if ($urandom_range(0, 1) == 1) rc(0, 0, 0, 8'h00, 8'h00, 0);
        else                           rc(1, 0, ~w, a + 8'd1, wd, 0);
      end else begin
        for (int k = 0; k < $urandom_range(1, 4); k++)
          rc(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom_range(0, 3)),
             8'($urandom), 1'($urandom));
      end
    end
    idle(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
